mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 12 +
 rtl/div_radix2.sv | 60 ++++++
 rtl/mdu_defines.sv | 8 +
 rtl/mdu_ctrl.sv | 141 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and helpers for the multiply/divide unit
package mdu_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} mdu_state_t;

  localparam int unsigned DIV_STEPS = 32;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic use_sign);
    return (use_sign && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - restoring radix-2 divider, one quotient bit per cycle
// Results are combinational on the done cycle so the caller can register them on that edge.
module div_radix2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);
  import mdu_pkg::*;

  logic [31:0] rem, quo, dsr;
  logic [4:0]  cnt;
  logic        neg_q, neg_r;
  logic [32:0] rem_sh, diff;
  logic [31:0] rem_nx, quo_nx;
  logic        qbit;

  // rem < dsr holds between steps, so diff[32] is a clean borrow flag
  assign rem_sh = {rem, quo[31]};
  assign diff   = rem_sh - {1'b0, dsr};
  assign qbit   = ~diff[32];
  assign rem_nx = qbit ? diff[31:0] : rem_sh[31:0];
  assign quo_nx = {quo[30:0], qbit};

  assign done      = busy && (cnt == 5'(DIV_STEPS - 1));
  assign quotient  = neg_q ? -quo_nx : quo_nx;
  assign remainder = neg_r ? -rem_nx : rem_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      quo   <= '0;
      dsr   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      rem   <= '0;
      quo   <= abs32(dividend, is_signed);
      dsr   <= abs32(divisor, is_signed);
      cnt   <= '0;
      busy  <= 1'b1;
      neg_q <= is_signed & (dividend[31] ^ divisor[31]);
      neg_r <= is_signed & dividend[31];
    end else if (busy) begin
      rem <= rem_nx;
      quo <= quo_nx;
      cnt <= cnt + 5'd1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_defines.sv
// rtl/mdu_defines.sv - shared ALUOP codes used by the EX stage and its helpers
`ifndef MDU_DEFINES_SV
`define MDU_DEFINES_SV
`define ALUOP_MULT  8'h18
`define ALUOP_MULTU 8'h19
`define ALUOP_DIV   8'h1A
`define ALUOP_DIVU  8'h1B
`endif

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - HI/LO multiply/divide controller with EX-stage stall handshake
// MDU_DIV_ZERO_FAST_EN: zero-divisor DIV/DIVU skips the iterative divider.
`include "mdu_defines.sv"
module mdu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [7:0]  aluop,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  input  logic        pipe_hold,
  output logic        stall_req,
  output logic        result_valid,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  import mdu_pkg::*;

  mdu_state_t  state, state_nx;
  logic [7:0]  aluop_q;
  logic [31:0] a_q, b_q;
  logic        is_mul, is_div, op_signed, div_fast;
  logic        accept, ld_mul, ld_div, ld_fast, div_start;
  logic        div_busy, div_done;
  logic [31:0] div_q, div_r;
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, prod;

  assign is_mul    = (aluop == `ALUOP_MULT) || (aluop == `ALUOP_MULTU);
  assign is_div    = (aluop == `ALUOP_DIV)  || (aluop == `ALUOP_DIVU);
  assign op_signed = (aluop == `ALUOP_MULT) || (aluop == `ALUOP_DIV);

`ifdef MDU_DIV_ZERO_FAST_EN
  assign div_fast = (src_b == 32'd0);
`else
  assign div_fast = 1'b0;
`endif

  // Sign-extend to 64 bits so one low-half multiply serves MULT and MULTU
  assign mul_signed = (aluop_q == `ALUOP_MULT);
  assign mul_a = mul_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign mul_b = mul_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign prod  = mul_a * mul_b;

  div_radix2 u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed (op_signed),
    .dividend  (src_a),
    .divisor   (src_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    stall_req    = 1'b0;
    result_valid = 1'b0;
    accept       = 1'b0;
    div_start    = 1'b0;
    ld_mul       = 1'b0;
    ld_div       = 1'b0;
    ld_fast      = 1'b0;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid && (is_mul || is_div)) begin
            accept    = 1'b1;
            stall_req = 1'b1;
            if (is_mul) begin
              state_nx = MUL;
            end else if (div_fast) begin
              ld_fast  = 1'b1;
              state_nx = DONE;
            end else begin
              div_start = 1'b1;
              state_nx  = DIV;
            end
          end
        end
        MUL: begin
          stall_req = 1'b1;
          ld_mul    = 1'b1;
          state_nx  = DONE;
        end
        DIV: begin
          stall_req = 1'b1;
          if (div_done) begin
            ld_div   = 1'b1;
            state_nx = DONE;
          end else if (!div_busy) begin
            state_nx = IDLE;
          end
        end
        DONE: begin
          result_valid = 1'b1;
          if (!pipe_hold) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluop_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else begin
      if (accept) begin
        aluop_q <= aluop;
        a_q     <= src_a;
        b_q     <= src_b;
      end
      if (ld_mul) begin
        hi_out <= prod[63:32];
        lo_out <= prod[31:0];
      end else if (ld_div) begin
        hi_out <= div_r;
        lo_out <= div_q;
      end else if (ld_fast) begin
        hi_out <= src_a;
        lo_out <= 32'hFFFF_FFFF;
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed self-checking bench for mdu_ctrl
module tb_mdu_ctrl;

  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;
`ifdef MDU_DIV_ZERO_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        op_valid = 1'b0;
  logic [7:0]  aluop = 8'h00;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        pipe_hold = 1'b0;
  logic        stall_req, result_valid;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  mdu_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .aluop        (aluop),
    .src_a        (src_a),
    .src_b        (src_b),
    .flush        (flush),
    .pipe_hold    (pipe_hold),
    .stall_req    (stall_req),
    .result_valid (result_valid),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue at cycle 0 (just after a falling edge) and measure cycles until result_valid
  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int   lat;
    logic stall_ok;
    op_valid = 1'b1; aluop = op; src_a = a; src_b = b;
    #1;
    chk1({tag, ".stall_c0"}, stall_req, 1'b1);
    lat = 0;
    stall_ok = 1'b1;
    do begin
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      lat++;
      if (!result_valid && !stall_req) stall_ok = 1'b0;
    end while (!result_valid && lat < 60);
    chk32({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk1({tag, ".stall_held"}, stall_ok, 1'b1);
    chk1({tag, ".stall_done"}, stall_req, 1'b0);
    chk32({tag, ".hi"}, hi_out, exp_hi);
    chk32({tag, ".lo"}, lo_out, exp_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_rv;

    @(negedge clk); #1;
    chk1("reset.stall", stall_req, 1'b0);
    chk1("reset.rv", result_valid, 1'b0);
    chk32("reset.hi", hi_out, 32'd0);
    chk32("reset.lo", lo_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    @(negedge clk); #1;
    chk1("mult_neg.rv_drop", result_valid, 1'b0);
    chk32("mult_neg.hi_hold", hi_out, 32'hFFFF_FFFF);
    chk32("mult_neg.lo_hold", lo_out, 32'hFFFF_FFFA);

    run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 2, 32'h0000_0001, 32'hFFFF_FFFE);
    @(negedge clk);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    @(negedge clk);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000);
    @(negedge clk);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    @(negedge clk);
    run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, DIV0_LAT, 32'd5, 32'hFFFF_FFFF);
    @(negedge clk);

    op_valid = 1'b1; aluop = 8'h21; src_a = 32'd9; src_b = 32'd9;
    #1;
    chk1("ignore.stall_c0", stall_req, 1'b0);
    @(negedge clk); op_valid = 1'b0; #1;
    chk1("ignore.stall_c1", stall_req, 1'b0);
    chk1("ignore.rv_c1", result_valid, 1'b0);

    @(negedge clk);
    flush = 1'b1; op_valid = 1'b1; aluop = OP_MULT; src_a = 32'd4; src_b = 32'd4;
    #1;
    chk1("flush_prio.stall", stall_req, 1'b0);
    @(negedge clk); flush = 1'b0; op_valid = 1'b0; #1;
    chk1("flush_prio.stall_c1", stall_req, 1'b0);
    chk1("flush_prio.rv_c1", result_valid, 1'b0);

    @(negedge clk);
    op_valid = 1'b1; aluop = OP_DIV; src_a = 32'd1000; src_b = 32'd3;
    #1;
    seen_rv = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); op_valid = 1'b0; #1;
      if (result_valid) seen_rv = 1'b1;
    end
    flush = 1'b1; #1;
    chk1("flush_div.stall_c10", stall_req, 1'b0);
    chk1("flush_div.rv_c10", result_valid, 1'b0);
    @(negedge clk); flush = 1'b0; #1;
    chk1("flush_div.stall_c11", stall_req, 1'b0);
    if (result_valid) seen_rv = 1'b1;
    chk1("flush_div.no_rv", seen_rv, 1'b0);
    @(negedge clk);
    run_op("mult_after_flush", OP_MULT, 32'd6, 32'd7, 2, 32'd0, 32'd42);
    @(negedge clk);

    pipe_hold = 1'b1;
    run_op("mult_hold", OP_MULT, 32'h0001_2345, 32'h0001_0000, 2, 32'h0000_0001, 32'h2345_0000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      op_valid = 1'b1; aluop = OP_MULTU; src_a = 32'd2; src_b = 32'd2;
      #1;
      chk1("hold.rv", result_valid, 1'b1);
      chk1("hold.stall", stall_req, 1'b0);
      chk32("hold.hi", hi_out, 32'h0000_0001);
      chk32("hold.lo", lo_out, 32'h2345_0000);
    end
    pipe_hold = 1'b0; #1;
    chk1("release.no_accept", stall_req, 1'b0);
    op_valid = 1'b0;
    @(negedge clk); #1;
    chk1("release.rv", result_valid, 1'b0);
    chk32("release.lo_hold", lo_out, 32'h2345_0000);

    @(negedge clk);
    op_valid = 1'b1; aluop = OP_DIV; src_a = 32'd100; src_b = 32'd7;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); op_valid = 1'b0;
    end
    #3 rst = 1'b1;
    #1;
    chk1("rst_mid.stall", stall_req, 1'b0);
    chk1("rst_mid.rv", result_valid, 1'b0);
    chk32("rst_mid.hi", hi_out, 32'd0);
    chk32("rst_mid.lo", lo_out, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    run_op("divu_after_rst", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
